// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : PC sequencer with an in-order fetch queue, redirect flush and
//               end-of-image handling (halt when IFU_BOUNDS_HALT_EN, else wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned MEM_BYTES = 32,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int          AW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int          CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
  localparam logic [31:0] LAST_PC  = 32'(MEM_BYTES - 4);
`ifdef IFU_BOUNDS_HALT_EN
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
`else
  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          halted_q, halted_d;
  logic [31:0]   fetch_count_q, fetch_count_d;
  logic [31:0]   pc_mem_q    [QDEPTH];
  logic [31:0]   instr_mem_q [QDEPTH];

  logic          w_full;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_target;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    w_valid  = (count_q != '0);
    w_full   = (count_q == FULL_CNT);
    w_pop    = w_valid && out_ready;
    w_push   = (state_q == S_FETCH) && (!w_full || w_pop) && !redirect_valid;
    w_target = {redirect_pc[31:2], 2'b00};
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    halted_d      = halted_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    fetch_count_d = fetch_count_q + (w_pop ? 32'd1 : 32'd0);

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      // A same-cycle handshake is still counted above; everything left is dropped.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
`ifdef IFU_BOUNDS_HALT_EN
      if (w_target >= MEM_LIMIT) begin
        state_d  = S_HALT;
        halted_d = 1'b1;
        pc_d     = LAST_PC;
      end else begin
        state_d  = S_FETCH;
        halted_d = 1'b0;
        pc_d     = w_target;
      end
`else
      state_d = S_FETCH;
      pc_d    = w_target & ADDR_MASK;
`endif
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(w_pop);
      wr_ptr_d = wr_ptr_q + AW'(w_push);
      count_d  = count_q + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        if (pc_q == LAST_PC) begin
`ifdef IFU_BOUNDS_HALT_EN
          state_d  = S_HALT;
          halted_d = 1'b1;
`else
          pc_d = RESET_PC;
`endif
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      pc_mem_q[wr_ptr_q]    <= pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instr;
    end
  end

  assign imem_pc     = pc_q;
  assign out_valid   = w_valid;
  assign out_pc      = w_valid ? pc_mem_q[rd_ptr_q] : 32'd0;
  assign out_instr   = w_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Scoreboard bench for instruction_fetch_unit (8-word image).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] imem [8];
  entry_t      sb [$];
  int          checks = 0;
  int          failures = 0;
  int          hs = 0;

  instruction_fetch_unit #(
    .RESET_PC (32'h0),
    .MEM_BYTES(32),
    .QDEPTH   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_pc       (imem_pc),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_instr = imem[imem_pc[4:2]];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic sb_push(input logic [31:0] pc);
    entry_t e;
    e.pc    = pc;
    e.instr = imem[pc[4:2]];
    sb.push_back(e);
  endtask

  // Compares each handshake against the scoreboard; leaves out_ready low.
  task automatic drain(input int n, input int budget);
    int     got;
    int     cyc;
    entry_t e;
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL drain_unexpected actual_pc=%h required=none", out_pc);
        end else begin
          e = sb.pop_front();
          if (out_pc !== e.pc || out_instr !== e.instr) begin
            failures++;
            $display("FAIL drain_entry actual=%h/%h required=%h/%h", out_pc, out_instr, e.pc, e.instr);
          end
        end
        got++;
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL drain_count actual=%0d required=%0d", got, n);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b0;
    sb.delete();
    hs = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid actual=%b required=0", out_valid); end
    checks++; if (out_pc !== 32'd0) begin failures++; $display("FAIL rst_out_pc actual=%h required=0", out_pc); end
    checks++; if (out_instr !== 32'd0) begin failures++; $display("FAIL rst_out_instr actual=%h required=0", out_instr); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted actual=%b required=0", halted); end
    checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL rst_count actual=%0d required=0", fetch_count); end
    checks++; if (imem_pc !== 32'd0) begin failures++; $display("FAIL rst_imem_pc actual=%h required=0", imem_pc); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL first_idle_valid actual=%b required=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL first_valid actual=%b required=1", out_valid); end
    checks++; if (out_instr !== 32'h00940333) begin failures++; $display("FAIL first_instr actual=%h required=00940333", out_instr); end
    sb_push(32'h0); sb_push(32'h4); sb_push(32'h8);
    drain(3, 3);
    checks++; if (fetch_count !== 32'(hs)) begin failures++; $display("FAIL first_count actual=%0d required=%0d", fetch_count, hs); end
  endtask

  task automatic test_backpressure();
    int waited;
    do_reset();
    waited = 0;
    while (out_valid !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid actual=%b required=1", out_valid); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_pc !== 32'h0 || out_instr !== 32'h00940333) begin
        failures++;
        $display("FAIL bp_head cycle=%0d actual=%h/%h required=0/00940333", k, out_pc, out_instr);
      end
      @(negedge clk);
    end
    checks++; if (imem_pc !== 32'h8) begin failures++; $display("FAIL bp_imem_pc actual=%h required=8", imem_pc); end
    sb_push(32'h0); sb_push(32'h4); sb_push(32'h8);
    out_ready = 1'b1;
    drain(3, 3);
    checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL bp_count actual=%0d required=3", fetch_count); end
  endtask

  task automatic test_redirect_full();
    do_reset();
    repeat (4) @(negedge clk);
    checks++; if (imem_pc !== 32'h8) begin failures++; $display("FAIL rd_pre_pc actual=%h required=8", imem_pc); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1E;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_flush_valid actual=%b required=0", out_valid); end
    checks++; if (imem_pc !== 32'h1C) begin failures++; $display("FAIL rd_imem_pc actual=%h required=1c", imem_pc); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h1C || out_instr !== 32'h00f768b3) begin
      failures++;
      $display("FAIL rd_target actual=%b/%h/%h required=1/1c/00f768b3", out_valid, out_pc, out_instr);
    end
    sb_push(32'h1C);
`ifdef IFU_BOUNDS_HALT_EN
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL rd_halted actual=%b required=1", halted); end
    checks++; if (imem_pc !== 32'h1C) begin failures++; $display("FAIL rd_halt_pc actual=%h required=1c", imem_pc); end
    out_ready = 1'b1;
    drain(1, 2);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_halt_drained actual=%b required=0", out_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rd_unhalt actual=%b required=0", halted); end
    checks++; if (imem_pc !== 32'h8) begin failures++; $display("FAIL rd_unhalt_pc actual=%h required=8", imem_pc); end
`else
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rd_halted actual=%b required=0", halted); end
    checks++; if (imem_pc !== 32'h0) begin failures++; $display("FAIL rd_wrap_pc actual=%h required=0", imem_pc); end
    sb_push(32'h0); sb_push(32'h4);
    out_ready = 1'b1;
    drain(3, 4);
`endif
  endtask

  task automatic test_boundary();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) sb_push(32'(k * 4));
    drain(8, 12);
    checks++; if (fetch_count !== 32'd8) begin failures++; $display("FAIL bnd_count actual=%0d required=8", fetch_count); end
`ifdef IFU_BOUNDS_HALT_EN
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL bnd_halted actual=%b required=1", halted); end
    checks++; if (imem_pc !== 32'h1C) begin failures++; $display("FAIL bnd_pc actual=%h required=1c", imem_pc); end
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bnd_empty actual=%b required=0", out_valid); end
`else
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL bnd_halted actual=%b required=0", halted); end
    sb_push(32'h0);
    out_ready = 1'b1;
    drain(1, 2);
`endif
  endtask

  task automatic test_redirect_handshake();
    do_reset();
    repeat (4) @(negedge clk);
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL rh_head actual=%h required=0", out_pc); end
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    hs++;
    @(negedge clk);
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (fetch_count !== 32'(hs)) begin failures++; $display("FAIL rh_count actual=%0d required=%0d", fetch_count, hs); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rh_flush actual=%b required=0", out_valid); end
    @(negedge clk);
    sb_push(32'h10); sb_push(32'h14);
    out_ready = 1'b1;
    drain(2, 2);
    checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL rh_total actual=%0d required=3", fetch_count); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) sb_push(32'(k * 4));
    drain(5, 8);
    repeat (3) @(negedge clk);
    checks++; if (fetch_count !== 32'd5) begin failures++; $display("FAIL mr_pre_count actual=%0d required=5", fetch_count); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mr_pre_valid actual=%b required=1", out_valid); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mr_valid actual=%b required=0", out_valid); end
    checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL mr_count actual=%0d required=0", fetch_count); end
    checks++; if (imem_pc !== 32'd0) begin failures++; $display("FAIL mr_pc actual=%h required=0", imem_pc); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL mr_halted actual=%b required=0", halted); end
    checks++; if (out_pc !== 32'd0 || out_instr !== 32'd0) begin failures++; $display("FAIL mr_out actual=%h/%h required=0/0", out_pc, out_instr); end
    reset = 1'b0;
  endtask

  initial begin
    imem[0] = 32'h00940333;
    imem[1] = 32'h413903b3;
    imem[2] = 32'h035a02b3;
    imem[3] = 32'h0062a023;
    imem[4] = 32'h00052283;
    imem[5] = 32'h40b50533;
    imem[6] = 32'h00c58463;
    imem[7] = 32'h00f768b3;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_full();
    test_boundary();
    test_redirect_handshake();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequences the instruction memory. The block owns the program counter and drives it to the memory. Each returned word is captured into a small in-order queue, and the queue presents `{pc, instruction}` pairs to decode through a valid/ready handshake. It also handles control-flow redirects by flushing the queue and reloading the PC, and it stops or wraps at the end of the memory image.

## Interface
- `RESET_PC`, 32'h0: PC loaded on reset; word-aligned.
- `MEM_BYTES`, 32: instruction memory size in bytes; power of two, at least 8.
- `QDEPTH`, 2: fetch queue entries; power of two, at least 2.

- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `imem_pc`, out, 32: address to instruction memory. Registered. Always word-aligned.
- `imem_instr`, in, 32: memory read data. Combinational from `imem_pc`, same cycle.
- `redirect_valid`, in, 1: single-cycle request to restart fetch.
- `redirect_pc`, in, 32: redirect target. Bits [1:0] are ignored (forced to 0).
- `out_valid`, out, 1: queue head valid.
- `out_ready`, in, 1: consumer accepts head.
- `out_pc`, out, 32: PC of head; 0 when `out_valid`=0.
- `out_instr`, out, 32: instruction at head; 0 when `out_valid`=0.
- `halted`, out, 1: fetch stopped at the memory bound.
- `fetch_count`, out, 32: count of completed output handshakes; wraps modulo 2^32.

## Operation
- FSM states: IDLE, FETCH, HALT.
- While `reset`=1, state IDLE. Reset values:
  - `imem_pc`=`RESET_PC`, queue empty, `out_valid`=0, `out_pc`=0, `out_instr`=0, `halted`=0, `fetch_count`=0.
- IDLE lasts exactly one cycle after reset deasserts, so the memory contents can settle. The next state is FETCH.
- FETCH push: on each edge where the queue is not full, or a pop occurs in the same cycle, and no redirect is active:
  - Push `{imem_pc, imem_instr}`.
  - `imem_pc` <= `imem_pc`+4.
- Pop: on each edge where `out_valid`=1 and `out_ready`=1, pop the head and increment `fetch_count`.
- Push and pop in the same cycle are legal at any occupancy, including full.
- Redirect takes priority over push:
  - A handshake in the same cycle still completes and is counted.
  - All remaining entries are flushed. No push occurs that cycle.
  - `imem_pc` <= `{redirect_pc[31:2],2'b00}`.
  - State becomes FETCH, even from HALT.
- End of image: the push of the word at `MEM_BYTES-4` is the boundary event. Behaviour depends on the configuration macro below.
- `reset` mid-operation overrides everything: queue discarded, all outputs return to their reset values at that edge.

## Timing
- Fetch latency: a word pushed at edge N is visible on `out_*` after edge N if the queue was empty. There is no combinational path from `imem_instr` to `out_*`.
- First instruction: `out_valid`=1 two cycles after `reset` deasserts (one IDLE cycle, then one fetch edge).
- Throughput: one instruction per cycle when `out_ready` is held at 1.
- Backpressure: when the queue is full and not popping, `imem_pc` holds.
- Redirect: `out_valid`=0 in the cycle after the redirect. The first target instruction appears one cycle after that.
- `halted` is registered. It asserts on the edge of the boundary event.

## Configuration
- `IFU_BOUNDS_HALT_EN` defined:
  - At the boundary push, state becomes HALT and `halted`=1.
  - `imem_pc` holds at `MEM_BYTES-4`. No further pushes; the queue drains normally.
  - A redirect with target >= `MEM_BYTES` enters HALT directly with an empty queue.
  - Any in-range redirect clears `halted`.
- `IFU_BOUNDS_HALT_EN` not defined:
  - At the boundary push, `imem_pc` wraps to `RESET_PC`.
  - Redirect targets are taken modulo `MEM_BYTES`.
  - HALT is unreachable and `halted` stays 0.

## Test plan
- Run from reset with `out_ready`=1: `out_valid` rises two cycles after reset release. `out_pc` then steps 0,4,8 with `out_instr` 0x00940333, 0x413903b3, 0x035a02b3, one per cycle.
- Hold `out_ready`=0 for 5 cycles after the first valid:
  - Queue fills to 2 entries. `imem_pc` holds at 8. Head stays at pc 0 / 0x00940333.
  - On release, pcs 0,4,8 arrive in order with none lost.
- Redirect to 0x1E while the queue is full:
  - Next cycle: `out_valid`=0, `imem_pc`=0x1C.
  - Following cycle: `out_pc`=0x1C, `out_instr`=0x00f768b3.
- Boundary, with the macro defined: after pc 0x1C is pushed, `halted`=1, `imem_pc`=0x1C, and exactly 8 handshakes total. Without the macro, `out_pc` 0x1C is followed by 0x0 / 0x00940333.
- Redirect coincident with a handshake: `fetch_count` increments by exactly 1, and the remaining queue entry is never presented.
- Assert `reset` with the queue full and `fetch_count`=5: at the next edge `out_valid`=0, `fetch_count`=0, `imem_pc`=0, `halted`=0.
